rob: RTL and testbench

Reorder buffer: circular FIFO of `ROB_PACKET` entries holding in-flight instructions in program order. Dispatch writes up to N packets per cycle at the tail; the head N entries are exposed combinationally to the retire stage, which returns how many to pop. A branch-mispredict tail restore squashes younger entries in one cycle.

---
 rtl/rob_pkg.sv | 23 ++
 rtl/rob_if.sv | 32 +++
 rtl/rob_sva.sv | 51 +++++
 rtl/rob.sv | 69 ++++++
 tb/tb_rob.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: the entry packet, default sizing and a saturation helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rob_pkg;

  // Default superscalar width and entry count.
  localparam int N_DEF      = 3;
  localparam int ROB_SZ_DEF = 32;

  // One in-flight instruction: rename tags plus a debug tag to trace program order.
  typedef struct packed {
    logic [7:0] tag;
    logic [5:0] T_new;
    logic [5:0] T_old;
    logic       has_dest;
  } ROB_PACKET;

  // Clamp a count to the superscalar width.
  function automatic int sat_width(input int value, input int width);
    return (value > width) ? width : value;
  endfunction

endpackage

// File: rtl/rob_if.sv
// Dispatch / retire / squash bundle between the pipeline and the reorder buffer.
// Latency: n/a (wires only).
// Backpressure: dispatch is throttled by rob_spots; retire by rob_outputs_valid.
interface rob_if
  import rob_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int ROB_SZ = ROB_SZ_DEF
);
  localparam int SB = $clog2(N + 1);
  localparam int PW = $clog2(ROB_SZ) + 1;

  ROB_PACKET [N-1:0] rob_inputs;
  logic [SB-1:0]     num_dispatching;
  logic [SB-1:0]     rob_spots;
  ROB_PACKET [N-1:0] rob_outputs;
  logic [SB-1:0]     rob_outputs_valid;
  logic [SB-1:0]     num_retiring;
  logic [PW-1:0]     rob_tail;
  logic              tail_restore_valid;
  logic [PW-1:0]     tail_restore;

  modport slave (
    input  rob_inputs, num_dispatching, num_retiring, tail_restore_valid, tail_restore,
    output rob_spots, rob_outputs, rob_outputs_valid, rob_tail
  );

  modport master (
    output rob_inputs, num_dispatching, num_retiring, tail_restore_valid, tail_restore,
    input  rob_spots, rob_outputs, rob_outputs_valid, rob_tail
  );
endinterface

// File: rtl/rob_sva.sv
// Protocol checker for the reorder buffer; observes the handshake only and shadows the head pointer.
// Latency: checks apply at each rising edge outside reset.
// Backpressure: flags dispatch beyond rob_spots or retire beyond rob_outputs_valid.
module rob_sva
  import rob_pkg::*;
#(
  parameter int ROB_SZ = ROB_SZ_DEF,
  parameter int N      = N_DEF
) (
  input logic                        clock,
  input logic                        reset,
  input logic [$clog2(N+1)-1:0]      num_dispatching,
  input logic [$clog2(N+1)-1:0]      rob_spots,
  input logic [$clog2(N+1)-1:0]      num_retiring,
  input logic [$clog2(N+1)-1:0]      rob_outputs_valid,
  input logic [$clog2(ROB_SZ):0]     rob_tail,
  input logic                        tail_restore_valid,
  input logic [$clog2(ROB_SZ):0]     tail_restore
);
  localparam int PW = $clog2(ROB_SZ) + 1;

  logic [PW-1:0] r_head;
  logic [PW-1:0] w_new_head;
  logic [PW-1:0] w_count;
  logic [PW-1:0] w_restore_off;
  logic [PW-1:0] w_tail_off;

  // Offsets relative to the post-retire head decide whether a restore is in range.
  always_comb begin
    w_new_head    = r_head + PW'(num_retiring);
    w_count       = rob_tail - r_head;
    w_restore_off = tail_restore - w_new_head;
    w_tail_off    = rob_tail - w_new_head;
  end

  // Head is reconstructed from the retire counts the pipeline reports.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_head <= '0;
    else        r_head <= w_new_head;
  end

  a_dispatch: assert property (@(posedge clock) disable iff (!reset)
    tail_restore_valid || (num_dispatching <= rob_spots));
  a_retire: assert property (@(posedge clock) disable iff (!reset)
    num_retiring <= rob_outputs_valid);
  a_count: assert property (@(posedge clock) disable iff (!reset)
    w_count <= PW'(ROB_SZ));
  a_restore: assert property (@(posedge clock) disable iff (!reset)
    tail_restore_valid |-> (w_restore_off <= w_tail_off));

endmodule

// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions, N-wide dispatch at tail, N-wide retire at head.
// Latency: dispatch visible on rob_outputs one edge later; outputs are combinational from registered state.
// Backpressure: rob_spots caps dispatch; a squash overrides the tail and drops same-cycle dispatch.
module rob
  import rob_pkg::*;
#(
  parameter int ROB_SZ = ROB_SZ_DEF,
  parameter int N      = N_DEF
) (
  input  logic clock,
  input  logic reset,
  rob_if.slave bus
);
  localparam int IDX = $clog2(ROB_SZ);
  localparam int PW  = IDX + 1;
  localparam int SB  = $clog2(N + 1);

  // Pointers carry one wrap bit above the index so full and empty differ.
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  ROB_PACKET     r_mem [ROB_SZ];

  logic [PW-1:0]  w_count;
  logic [PW-1:0]  w_free;
  logic [PW-1:0]  w_next_head;
  logic [PW-1:0]  w_next_tail;
  logic [IDX-1:0] w_rd_idx [N];
  logic [IDX-1:0] w_wr_idx [N];

  // Occupancy, free space and the head window, all from registered state only.
  always_comb begin
    w_count = r_tail - r_head;
    w_free  = PW'(ROB_SZ) - w_count;
    bus.rob_spots         = (w_free  > PW'(N)) ? SB'(N) : SB'(w_free);
    bus.rob_outputs_valid = (w_count > PW'(N)) ? SB'(N) : SB'(w_count);
    bus.rob_tail          = r_tail;
    bus.rob_outputs       = '0;
    for (int i = 0; i < N; i++) begin
      w_rd_idx[i] = IDX'(r_head + PW'(i));
      w_wr_idx[i] = IDX'(r_tail + PW'(i));
      bus.rob_outputs[i] = r_mem[w_rd_idx[i]];
    end
  end

  // Pointer advance; a squash takes priority over dispatch for the tail only.
  always_comb begin
    w_next_head = r_head + PW'(bus.num_retiring);
    w_next_tail = bus.tail_restore_valid ? bus.tail_restore
                                         : r_tail + PW'(bus.num_dispatching);
  end

  // State update: retired entries are left in place; squashed cycles write nothing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < ROB_SZ; i++) r_mem[i] <= '0;
    end else begin
      r_head <= w_next_head;
      r_tail <= w_next_tail;
      if (!bus.tail_restore_valid) begin
        for (int i = 0; i < N; i++) begin
          if (i < int'(bus.num_dispatching)) r_mem[w_wr_idx[i]] <= bus.rob_inputs[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Scenario bench for rob with N=3, ROB_SZ=8 against a queue reference model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: stimulus always respects rob_spots / occupancy.
module tb_rob;
  import rob_pkg::*;

  localparam int N      = 3;
  localparam int ROB_SZ = 8;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;
  int pkt_cnt;

  ROB_PACKET   mq [$];
  logic [3:0]  m_head;
  logic [3:0]  m_tail;

  rob_if #(.N(N), .ROB_SZ(ROB_SZ)) bus ();

  rob #(.ROB_SZ(ROB_SZ), .N(N)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  rob_sva #(.ROB_SZ(ROB_SZ), .N(N)) sva (
    .clock              (clk),
    .reset              (rst_n),
    .num_dispatching    (bus.num_dispatching),
    .rob_spots          (bus.rob_spots),
    .num_retiring       (bus.num_retiring),
    .rob_outputs_valid  (bus.rob_outputs_valid),
    .rob_tail           (bus.rob_tail),
    .tail_restore_valid (bus.tail_restore_valid),
    .tail_restore       (bus.tail_restore)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ROB_PACKET mk_pkt();
    ROB_PACKET p;
    pkt_cnt++;
    p.tag      = 8'(pkt_cnt);
    p.T_new    = 6'(pkt_cnt * 5);
    p.T_old    = 6'(pkt_cnt + 17);
    p.has_dest = 1'(pkt_cnt);
    return p;
  endfunction

  task automatic clear_inputs();
    bus.rob_inputs         = '0;
    bus.num_dispatching    = '0;
    bus.num_retiring       = '0;
    bus.tail_restore_valid = 1'b0;
    bus.tail_restore       = '0;
  endtask

  // Drive one cycle and advance the reference model; returns 1 time unit after the edge.
  task automatic cycle(input int nd, input int nr, input bit sq, input logic [3:0] rp);
    int keep;
    bus.num_dispatching    = 2'(nd);
    bus.num_retiring       = 2'(nr);
    bus.tail_restore_valid = sq;
    bus.tail_restore       = rp;
    for (int i = 0; i < N; i++) bus.rob_inputs[i] = (i < nd) ? mk_pkt() : '0;
    for (int k = 0; k < nr; k++) void'(mq.pop_front());
    m_head = m_head + 4'(nr);
    if (sq) begin
      m_tail = rp;
      keep = int'(4'(rp - m_head));
      while (mq.size() > keep) void'(mq.pop_back());
    end else begin
      for (int i = 0; i < nd; i++) mq.push_back(bus.rob_inputs[i]);
      m_tail = m_tail + 4'(nd);
    end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    m_head = '0;
    m_tail = '0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.rob_spots !== 2'd3) begin
      n_fail++; $display("FAIL reset_spots got %0d want 3", bus.rob_spots);
    end
    n_checks++;
    if (bus.rob_outputs_valid !== 2'd0) begin
      n_fail++; $display("FAIL reset_valid got %0d want 0", bus.rob_outputs_valid);
    end
    n_checks++;
    if (bus.rob_tail !== 4'd0) begin
      n_fail++; $display("FAIL reset_tail got %0d want 0", bus.rob_tail);
    end
    n_checks++;
    if (bus.rob_outputs !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", bus.rob_outputs);
    end
  endtask

  task automatic test_fill();
    ROB_PACKET first;
    cycle(3, 0, 1'b0, 4'd0);
    first = mq[0];
    cycle(3, 0, 1'b0, 4'd0);
    cycle(2, 0, 1'b0, 4'd0);
    n_checks++;
    if (bus.rob_tail !== 4'd8) begin
      n_fail++; $display("FAIL fill_tail got %0d want 8", bus.rob_tail);
    end
    n_checks++;
    if (bus.rob_spots !== 2'd0) begin
      n_fail++; $display("FAIL fill_spots got %0d want 0", bus.rob_spots);
    end
    n_checks++;
    if (bus.rob_outputs_valid !== 2'd3) begin
      n_fail++; $display("FAIL fill_valid got %0d want 3", bus.rob_outputs_valid);
    end
    n_checks++;
    if (bus.rob_outputs[0] !== first) begin
      n_fail++; $display("FAIL fill_head_pkt got %h want %h", bus.rob_outputs[0], first);
    end
  endtask

  task automatic test_wrap();
    cycle(0, 3, 1'b0, 4'd0);
    n_checks++;
    if (bus.rob_spots !== 2'd3) begin
      n_fail++; $display("FAIL wrap_spots_after_retire got %0d want 3", bus.rob_spots);
    end
    cycle(3, 3, 1'b0, 4'd0);
    n_checks++;
    if (bus.rob_tail !== 4'd11) begin
      n_fail++; $display("FAIL wrap_tail got %0d want 11", bus.rob_tail);
    end
    n_checks++;
    if (bus.rob_spots !== 2'd3) begin
      n_fail++; $display("FAIL wrap_spots got %0d want 3", bus.rob_spots);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (bus.rob_outputs[i] !== mq[i]) begin
        n_fail++; $display("FAIL wrap_order slot %0d got %h want %h", i, bus.rob_outputs[i], mq[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    ROB_PACKET survivor;
    cycle(0, 1, 1'b0, 4'd0);
    survivor = mq[3];
    cycle(2, 3, 1'b0, 4'd0);
    n_checks++;
    if (bus.rob_outputs_valid !== 2'd3 || bus.rob_spots !== 2'd3 || bus.rob_tail !== 4'd13) begin
      n_fail++;
      $display("FAIL simul_counts got valid=%0d spots=%0d tail=%0d want 3 3 13",
               bus.rob_outputs_valid, bus.rob_spots, bus.rob_tail);
    end
    n_checks++;
    if (bus.rob_outputs[0] !== survivor) begin
      n_fail++; $display("FAIL simul_survivor got %h want %h", bus.rob_outputs[0], survivor);
    end
    for (int i = 1; i < N; i++) begin
      n_checks++;
      if (bus.rob_outputs[i] !== mq[i]) begin
        n_fail++; $display("FAIL simul_new slot %0d got %h want %h", i, bus.rob_outputs[i], mq[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(2, 0, 1'b0, 4'd0);
    n_checks++;
    if (mq.size() != 5 || bus.rob_outputs_valid !== 2'd3) begin
      n_fail++; $display("FAIL areset_setup got valid=%0d model=%0d want 3 5",
                         bus.rob_outputs_valid, mq.size());
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.rob_spots !== 2'd3 || bus.rob_outputs_valid !== 2'd0 ||
        bus.rob_tail !== 4'd0 || bus.rob_outputs !== '0) begin
      n_fail++;
      $display("FAIL areset_outputs got spots=%0d valid=%0d tail=%0d out=%h want 3 0 0 0",
               bus.rob_spots, bus.rob_outputs_valid, bus.rob_tail, bus.rob_outputs);
    end
    #2 rst_n = 1'b1;
    mq.delete();
    m_head = '0;
    m_tail = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_squash();
    ROB_PACKET keep0;
    ROB_PACKET stale2;
    ROB_PACKET stale3;
    do_reset();
    cycle(3, 0, 1'b0, 4'd0);
    cycle(3, 0, 1'b0, 4'd0);
    keep0  = mq[1];
    stale2 = mq[2];
    stale3 = mq[3];
    cycle(3, 1, 1'b1, 4'd2);
    n_checks++;
    if (bus.rob_tail !== 4'd2) begin
      n_fail++; $display("FAIL squash_tail got %0d want 2", bus.rob_tail);
    end
    n_checks++;
    if (bus.rob_outputs_valid !== 2'd1 || bus.rob_spots !== 2'd3) begin
      n_fail++; $display("FAIL squash_counts got valid=%0d spots=%0d want 1 3",
                         bus.rob_outputs_valid, bus.rob_spots);
    end
    n_checks++;
    if (bus.rob_outputs[0] !== keep0) begin
      n_fail++; $display("FAIL squash_head got %h want %h", bus.rob_outputs[0], keep0);
    end
    n_checks++;
    if (bus.rob_outputs[1] !== stale2 || bus.rob_outputs[2] !== stale3) begin
      n_fail++; $display("FAIL squash_no_write got %h %h want %h %h",
                         bus.rob_outputs[1], bus.rob_outputs[2], stale2, stale3);
    end
  endtask

  task automatic test_random();
    int s, nr, nd, spots, ev, es;
    bit sq;
    logic [3:0] rp;
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      s     = mq.size();
      nr    = $urandom_range(sat_width(s, N), 0);
      spots = sat_width(ROB_SZ - s, N);
      nd    = $urandom_range(spots, 0);
      sq    = ($urandom_range(9, 0) == 0);
      rp    = m_head + 4'(nr) + 4'($urandom_range(s - nr, 0));
      cycle(nd, nr, sq, rp);
      ev = sat_width(mq.size(), N);
      es = sat_width(ROB_SZ - mq.size(), N);
      n_checks++;
      if (bus.rob_tail !== m_tail || bus.rob_outputs_valid !== 2'(ev) || bus.rob_spots !== 2'(es)) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL rand_state cyc %0d got tail=%0d valid=%0d spots=%0d want %0d %0d %0d",
                   c, bus.rob_tail, bus.rob_outputs_valid, bus.rob_spots, m_tail, ev, es);
        bad++;
      end
      for (int i = 0; i < ev; i++) begin
        n_checks++;
        if (bus.rob_outputs[i] !== mq[i]) begin
          n_fail++;
          if (bad < 10)
            $display("FAIL rand_pkt cyc %0d slot %0d got %h want %h", c, i, bus.rob_outputs[i], mq[i]);
          bad++;
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pkt_cnt  = 0;
    m_head   = '0;
    m_tail   = '0;
    rst_n    = 1'b0;
    clear_inputs();
    test_reset();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    test_squash();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
